// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: small-sigma rotate/shift amounts, schedule FSM states,
// and the word-width to round-count mapping used to reject illegal configurations.
package sha2_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // SHA-256 small sigmas: {rotr, rotr, shr}
  localparam int SIG256_S0_R1 = 7;
  localparam int SIG256_S0_R2 = 18;
  localparam int SIG256_S0_SH = 3;
  localparam int SIG256_S1_R1 = 17;
  localparam int SIG256_S1_R2 = 19;
  localparam int SIG256_S1_SH = 10;

  // SHA-512 small sigmas: {rotr, rotr, shr}
  localparam int SIG512_S0_R1 = 1;
  localparam int SIG512_S0_R2 = 8;
  localparam int SIG512_S0_SH = 7;
  localparam int SIG512_S1_R1 = 19;
  localparam int SIG512_S1_R2 = 61;
  localparam int SIG512_S1_SH = 6;

  // Returns 0 for an unsupported width so any ROUNDS value mismatches.
  function automatic int rounds_for(input int word_w);
    case (word_w)
      32:      return 64;
      64:      return 80;
      default: return 0;
    endcase
  endfunction

  // idx 0/1 select the rotate amounts, idx 2 the logical shift; sel picks sigma1.
  function automatic int sigma_const(input int word_w, input bit sel, input int idx);
    int c [3];
    if (word_w == 64) begin
      c = sel ? '{SIG512_S1_R1, SIG512_S1_R2, SIG512_S1_SH}
              : '{SIG512_S0_R1, SIG512_S0_R2, SIG512_S0_SH};
    end else begin
      c = sel ? '{SIG256_S1_R1, SIG256_S1_R2, SIG256_S1_SH}
              : '{SIG256_S0_R1, SIG256_S0_R2, SIG256_S0_SH};
    end
    return c[idx];
  endfunction

endpackage

// File: rtl/sha2_small_sigma.sv
// Combinational SHA-2 small sigma (sigma0 when SEL=0, sigma1 when SEL=1)
// for 32- or 64-bit words.
module sha2_small_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter bit SEL    = 1'b0
) (
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_y
);

  localparam int R1 = sigma_const(WORD_W, SEL, 0);
  localparam int R2 = sigma_const(WORD_W, SEL, 1);
  localparam int SH = sigma_const(WORD_W, SEL, 2);

  logic [WORD_W-1:0] w_rot1;
  logic [WORD_W-1:0] w_rot2;

  assign w_rot1 = (i_x >> R1) | (i_x << (WORD_W - R1));
  assign w_rot2 = (i_x >> R2) | (i_x << (WORD_W - R2));
  assign o_y    = w_rot1 ^ w_rot2 ^ (i_x >> SH);

endmodule

// File: rtl/sha2_msg_schedule.sv
// SHA-256/512 message-schedule generator: loads a 16-word block and streams W[0..ROUNDS-1].
// Define SHA2_MSG_SCHED_PREFETCH_EN to add a one-block buffer for bubble-free back-to-back blocks.
module sha2_msg_schedule
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [16*WORD_W-1:0]      block_i,
  input  logic                      block_valid_i,
  output logic                      block_ready_o,
  input  logic                      abort_i,
  output logic [WORD_W-1:0]         w_o,
  output logic [$clog2(ROUNDS)-1:0] w_round_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic                      w_last_o,
  output logic                      busy_o
);

  localparam int             RW     = $clog2(ROUNDS);
  localparam logic [RW-1:0]  T_LAST = RW'(ROUNDS - 1);
  localparam logic [RW-1:0]  T_PRE  = RW'(ROUNDS - 2);

  generate
    if (ROUNDS != rounds_for(WORD_W)) begin : g_bad_cfg
      $error("sha2_msg_schedule: WORD_W must be 32 (ROUNDS=64) or 64 (ROUNDS=80)");
    end
  endgenerate

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WORD_W-1:0] r_w [16];
  logic [RW-1:0]     r_t;
  logic              r_last;

  logic              w_accept;
  logic              w_xfer;
  logic              w_last_xfer;
  logic              w_refill;
  logic              w_load;
  logic [16*WORD_W-1:0] w_load_src;
  logic [WORD_W-1:0] w_sig0;
  logic [WORD_W-1:0] w_sig1;
  logic [WORD_W-1:0] w_next;

`ifdef SHA2_MSG_SCHED_PREFETCH_EN
  logic [16*WORD_W-1:0] r_buf;
  logic                 r_full;
  logic                 w_buf_wr;

  assign w_refill   = r_full || w_accept;
  assign w_load_src = (r_state == ST_STREAM && r_full) ? r_buf : block_i;
  assign w_buf_wr   = (r_state == ST_STREAM) && w_accept && !w_last_xfer;
`else
  assign w_refill   = 1'b0;
  assign w_load_src = block_i;
`endif

  assign w_accept    = block_valid_i && block_ready_o;
  assign w_xfer      = w_valid_o && w_ready_i;
  assign w_last_xfer = w_xfer && (r_t == T_LAST);
  assign w_load      = ((r_state == ST_IDLE) && w_accept) || (w_last_xfer && w_refill);

  sha2_small_sigma #(.WORD_W(WORD_W), .SEL(1'b0)) u_sigma0 (.i_x(r_w[1]),  .o_y(w_sig0));
  sha2_small_sigma #(.WORD_W(WORD_W), .SEL(1'b1)) u_sigma1 (.i_x(r_w[14]), .o_y(w_sig1));

  assign w_next = w_sig1 + r_w[9] + w_sig0 + r_w[0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: each combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (abort_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:   if (w_accept) w_state_nxt = ST_STREAM;
        ST_STREAM: if (w_last_xfer && !w_refill) w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    block_ready_o = 1'b0;
    w_valid_o     = 1'b0;
    busy_o        = 1'b0;
    unique case (r_state)
      ST_IDLE: block_ready_o = !abort_i;
      ST_STREAM: begin
        w_valid_o = 1'b1;
        busy_o    = 1'b1;
`ifdef SHA2_MSG_SCHED_PREFETCH_EN
        block_ready_o = !r_full && !abort_i;
`endif
      end
    endcase
  end

  // NOTE: the shift register is reset because w_o must read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_t    <= '0;
      r_last <= 1'b0;
    end else if (abort_i) begin
      r_t    <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      for (int i = 0; i < 16; i++) r_w[i] <= w_load_src[(15-i)*WORD_W +: WORD_W];
      r_t    <= '0;
      r_last <= 1'b0;
    end else if (w_xfer) begin
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_next;
      r_t     <= w_last_xfer ? '0 : r_t + RW'(1);
      r_last  <= !w_last_xfer && (r_t == T_PRE);
    end
  end

`ifdef SHA2_MSG_SCHED_PREFETCH_EN
  // The buffer payload is only meaningful while r_full is set, so it carries no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (abort_i) begin
      r_full <= 1'b0;
    end else if (w_load && r_state == ST_STREAM && r_full) begin
      r_full <= 1'b0;
    end else if (w_buf_wr) begin
      r_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_wr) r_buf <= block_i;
  end
`endif

  assign w_o       = r_w[0];
  assign w_round_o = r_t;
  assign w_last_o  = r_last;

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Self-checking bench for sha2_msg_schedule: SHA-256 and SHA-512 instances checked
// against a textbook W[t] recurrence model, with stalls, back-to-back, abort and reset.
module tb_sha2_msg_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [511:0]  b32;
  logic [1023:0] b64;
  logic          bv32, bv64, ab32, ab64, wr32, wr64;
  logic          rdy32, rdy64, vld32, vld64, last32, last64, busy32, busy64;
  logic [31:0]   w32;
  logic [63:0]   w64;
  logic [5:0]    rnd32;
  logic [6:0]    rnd64;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] obs_w [80];
  logic [63:0] ma [16], mb [16];
  logic [63:0] wa [80], wb [80];
  int          acc;

  sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .block_i(b32), .block_valid_i(bv32), .block_ready_o(rdy32),
    .abort_i(ab32), .w_o(w32), .w_round_o(rnd32), .w_valid_o(vld32), .w_ready_i(wr32),
    .w_last_o(last32), .busy_o(busy32)
  );

  sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .block_i(b64), .block_valid_i(bv64), .block_ready_o(rdy64),
    .abort_i(ab64), .w_o(w64), .w_round_o(rnd64), .w_valid_o(vld64), .w_ready_i(wr64),
    .w_last_o(last64), .busy_o(busy64)
  );

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] wmask(input int ww);
    return (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int ww);
    return ((x >> r) | (x << (ww - r))) & wmask(ww);
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x, input int ww);
    if (ww == 32) return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
    return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x, input int ww);
    if (ww == 32) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
    return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
  endfunction

  task automatic model(input int ww, input logic [63:0] m [16], output logic [63:0] w [80]);
    for (int t = 0; t < 16; t++) w[t] = m[t] & wmask(ww);
    for (int t = 16; t < 80; t++)
      w[t] = (ssig1(w[t-2], ww) + w[t-7] + ssig0(w[t-15], ww) + w[t-16]) & wmask(ww);
  endtask

  task automatic rand_block(input int ww, output logic [63:0] m [16]);
    for (int i = 0; i < 16; i++) m[i] = {$urandom, $urandom} & wmask(ww);
  endtask

  // ---------------- DUT access helpers ----------------
  function automatic logic [63:0] cur_w(input int sel);
    return sel ? w64 : {32'h0, w32};
  endfunction
  function automatic logic [63:0] cur_rnd(input int sel);
    return sel ? {57'h0, rnd64} : {58'h0, rnd32};
  endfunction

  task automatic put_block(input int sel, input logic [63:0] m [16]);
    for (int i = 0; i < 16; i++) begin
      if (sel) b64[(15-i)*64 +: 64] = m[i];
      else     b32[(15-i)*32 +: 32] = m[i][31:0];
    end
  endtask

  task automatic offer(input int sel, input logic [63:0] m [16]);
    put_block(sel, m);
    if (sel) bv64 = 1'b1; else bv32 = 1'b1;
    check($sformatf("ready_idle_%0d", sel), sel ? rdy64 : rdy32, 1'b1);
    tick();
    if (sel) bv64 = 1'b0; else bv32 = 1'b0;
  endtask

  // Consume words until index upto has been transferred away; checks every cycle.
  task automatic stream(input int sel, input logic [63:0] w [80], input int upto,
                        input int stall, output int n_acc);
    int t      = 0;
    int cyc    = 0;
    int rounds = sel ? 80 : 64;
    logic r, a;
    n_acc = 0;
    while (t < upto && cyc < 2000) begin
      check($sformatf("valid_%0d_t%0d", sel, t), sel ? vld64 : vld32, 1'b1);
      check($sformatf("w_%0d_t%0d", sel, t), cur_w(sel), w[t]);
      check($sformatf("round_%0d_t%0d", sel, t), cur_rnd(sel), 64'(t));
      check($sformatf("last_%0d_t%0d", sel, t), sel ? last64 : last32, t == rounds - 1);
      obs_w[t] = cur_w(sel);
      r = (stall == 0) || ($urandom_range(99) >= stall);
      if (sel) wr64 = r; else wr32 = r;
      a = sel ? (bv64 && rdy64) : (bv32 && rdy32);
      tick();
      if (a) begin
        n_acc++;
        if (sel) bv64 = 1'b0; else bv32 = 1'b0;
      end
      if (r) t++;
      cyc++;
    end
    if (sel) wr64 = 1'b0; else wr32 = 1'b0;
    if (t < upto) begin
      n_cmp++;
      n_fail++;
      $error("FAIL stream_timeout_%0d: reached t=%0d required t=%0d", sel, t, upto);
    end
  endtask

  task automatic check_reset_outputs(input int sel);
    check($sformatf("rst_w_%0d", sel), cur_w(sel), 64'h0);
    check($sformatf("rst_round_%0d", sel), cur_rnd(sel), 64'h0);
    check($sformatf("rst_valid_%0d", sel), sel ? vld64 : vld32, 1'b0);
    check($sformatf("rst_last_%0d", sel), sel ? last64 : last32, 1'b0);
    check($sformatf("rst_busy_%0d", sel), sel ? busy64 : busy32, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    b32 = '0; b64 = '0;
    bv32 = 1'b0; bv64 = 1'b0; ab32 = 1'b0; ab64 = 1'b0; wr32 = 1'b0; wr64 = 1'b0;
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("ready_after_rst_32", rdy32, 1'b1);
    check("ready_after_rst_64", rdy64, 1'b1);

    // SHA-256 "abc" block, no stalls
    for (int i = 0; i < 16; i++) ma[i] = '0;
    ma[0]  = 64'h6162_6380;
    ma[15] = 64'h18;
    model(32, ma, wa);
    offer(0, ma);
    stream(0, wa, 64, 0, acc);
    check("abc256_w0",  obs_w[0],  64'h6162_6380);
    check("abc256_w15", obs_w[15], 64'h18);
    check("abc256_w16", obs_w[16], 64'h6162_6380);
    check("abc256_w17", obs_w[17], 64'h000F_0000);
    check("idle_after_block_32", vld32, 1'b0);

    // Random block under 50% consumer stalls
    rand_block(32, ma);
    model(32, ma, wa);
    offer(0, ma);
    stream(0, wa, 64, 50, acc);

    // Back-to-back blocks: second offered while the first streams
    rand_block(32, ma);
    rand_block(32, mb);
    model(32, ma, wa);
    model(32, mb, wb);
    offer(0, ma);
    put_block(0, mb);
    bv32 = 1'b1;
    stream(0, wa, 64, 50, acc);
`ifdef SHA2_MSG_SCHED_PREFETCH_EN
    check("b2b_prefetch_accepts", 64'(acc), 64'd1);
    stream(0, wb, 64, 0, acc);
`else
    check("b2b_no_accept_in_stream", 64'(acc), 64'd0);
    check("b2b_bubble_valid", vld32, 1'b0);
    check("b2b_bubble_ready", rdy32, 1'b1);
    tick();
    bv32 = 1'b0;
    stream(0, wb, 64, 0, acc);
`endif

    // Abort at t=20 with a coincident block offer and word transfer
    rand_block(32, ma);
    rand_block(32, mb);
    model(32, ma, wa);
    model(32, mb, wb);
    offer(0, ma);
    stream(0, wa, 20, 50, acc);
    put_block(0, mb);
    bv32 = 1'b1;
    ab32 = 1'b1;
    wr32 = 1'b1;
    #1;
    check("abort_ready_low", rdy32, 1'b0);
    check("abort_w20_held", {32'h0, w32}, wa[20]);
    tick();
    ab32 = 1'b0;
    bv32 = 1'b0;
    wr32 = 1'b0;
    check("abort_valid_low", vld32, 1'b0);
    check("abort_round_clr", {58'h0, rnd32}, 64'h0);
    check("abort_busy_low", busy32, 1'b0);
    tick();
    check("abort_block_not_taken", vld32, 1'b0);
    offer(0, mb);
    stream(0, wb, 64, 30, acc);

    // Reset pulse mid-stream at t=30
    rand_block(32, ma);
    model(32, ma, wa);
    offer(0, ma);
    stream(0, wa, 30, 50, acc);
    rst = 1'b1;
    #1;
    check_reset_outputs(0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("ready_after_midrst", rdy32, 1'b1);
    check("valid_after_midrst", vld32, 1'b0);
    rand_block(32, ma);
    model(32, ma, wa);
    offer(0, ma);
    stream(0, wa, 64, 0, acc);

    // SHA-512 "abc" block
    for (int i = 0; i < 16; i++) ma[i] = '0;
    ma[0]  = 64'h6162_6380_0000_0000;
    ma[15] = 64'h18;
    model(64, ma, wa);
    offer(1, ma);
    stream(1, wa, 80, 0, acc);
    check("abc512_w0",  obs_w[0],  64'h6162_6380_0000_0000);
    check("abc512_w15", obs_w[15], 64'h18);
    check("abc512_w16", obs_w[16], 64'h6162_6380_0000_0000);
    check("abc512_w17", obs_w[17], 64'h0003_0000_0000_00C0);
    check("idle_after_block_64", vld64, 1'b0);

    // Random SHA-512 block under stalls
    rand_block(64, ma);
    model(64, ma, wa);
    offer(1, ma);
    stream(1, wa, 80, 50, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
